cgra_regfile_write_arbiter: RTL and testbench
=============================================

# cgra_regfile_write_arbiter

Shares the two write ports of a CGRA processing element's 8×32-bit register file among NREQ independent write requesters. Each requester uses a valid/ready handshake. Up to two requests are granted per cycle in round-robin order, and the winners are driven onto the register file's WE0/WE1, address_in0/1 and in0/1 through registered outputs. The block sits between the PE's functional-unit result buses and the register file.

## Interface
- NREQ, 4, number of write requesters (2..8)
- log2regs, 3, register-file address width
- size, 32, data width
- CGRA_Clock  in  1  clock
- CGRA_Reset  in  1  asynchronous, active-high reset
- hold  in  1  when high, no grants are issued (config/reconfiguration freeze)
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant; combinational from the current state and inputs
- req_addr  in  NREQ*log2regs  packed target addresses; requester i occupies slice i
- req_data  in  NREQ*size  packed write data; requester i occupies slice i
- WE0, WE1  out  1  register-file write enables (registered)
- address_in0, address_in1  out  log2regs  register-file write addresses (registered)
- in0, in1  out  size  register-file write data (registered)
- stall_count  out  NREQ*16  saturating stall counters; present only with CGRA_REGFILE_ARB_STATS_EN

## Operation
- State: rr_ptr (ceil log2 NREQ bits), which is the highest-priority requester index.
- Each cycle, with hold=0:
  - Pick A: the first requester with valid=1, scanning from rr_ptr upward with wrap-around.
  - Pick B: the next requester after A, in the same scan order, with valid=1 and an address different from A's address.
- Same-address conflict: a requester matching A's address is skipped this cycle. It keeps valid asserted and is retried.
- req_ready[i]=1 only for A or B. Handshake completes when valid && ready. A requester must hold addr and data stable until ready.
- Port mapping: A goes to port 0 and B goes to port 1, so WE0 and WE1 never target the same address.
- Output registers, next cycle:
  - WE0=A exists, address_in0/in0 take A's values.
  - WE1=B exists, address_in1/in1 take B's values.
  - When a port has no winner, its WE is 0 and its address/data hold their previous value.
- rr_ptr update:
  - Two grants: rr_ptr becomes B+1, mod NREQ.
  - One grant: rr_ptr becomes A+1, mod NREQ.
  - No grant: rr_ptr holds.
- hold=1: req_ready is all 0, WE0/WE1 are 0 next cycle, and rr_ptr holds. hold takes priority over all valids.
- NREQ valids all high with distinct addresses: exactly two grants per cycle. Every requester is served within ceil(NREQ/2) cycles.

## Timing
- Reset (asynchronous, takes effect immediately): WE0=WE1=0, address_in0/1=0, in0/in1=0, rr_ptr=0, stall_count=0. req_ready follows combinationally, so it is 0 while CGRA_Reset is high.
- Handshake at edge N: WE/address/data are on the outputs after edge N. The register file captures them at edge N+1. The data is readable on the register-file outputs after edge N+2.
- Reset mid-operation: an in-flight registered write is dropped (WE cleared). Requesters must re-present.
- No combinational path from req_* to WE/address/in outputs. A combinational path exists from req_valid/req_addr/hold to req_ready.

## Configuration
- CGRA_REGFILE_ARB_STATS_EN defined:
  - stall_count is present.
  - Counter i increments each cycle that req_valid[i]=1 and req_ready[i]=0, including cycles with hold=1.
  - Counters saturate at 16'hFFFF and clear only on reset.
- Not defined: stall_count port and counters are absent. Behaviour is otherwise identical.

## Structure
- Package cgra_regfile_arb_pkg holds:
  - default constants: NREQ_DEFAULT=4, LOG2REGS_DEFAULT=3, SIZE_DEFAULT=32, STALL_CNT_W=16
  - typedef for the rr pointer width
- Sub-module cgra_rr_pick: combinational first-set-bit scan from a start index with wrap-around. Inputs: request mask and start index. Outputs: found flag and index. It is instantiated twice:
  - pick A: mask = valid
  - pick B: mask = valid & ~onehot(A) & ~addr_match(A), start index = A+1

## Test plan
- Reset: assert CGRA_Reset mid-cycle with all valids high → WE0=WE1=0, outputs 0, req_ready=0 immediately. After release, the first grants go to requesters 0 and 1.
- Full load, NREQ=4, addresses 0..3, data 32'hA0..A3 held continuously → grant pairs (0,1),(2,3),(0,1),… The register file reads 32'hA0..A3 at addresses 0..3.
- Conflict: req0 and req1 both write address 5 (data 11, 22), req2 writes address 6 (data 33) → cycle 1 grants req0 (port 0) and req2 (port 1). Cycle 2 grants req1. Final reg[5]=22.
- Single requester: only req3 is valid, address 7, data 32'hDEADBEEF → req_ready[3]=1 immediately. WE0=1 and WE1=0 the next cycle. rr_ptr becomes 0.
- hold: hold=1 for 3 cycles with req1 valid → req_ready=0 and WE=0 throughout. With STATS_EN, stall_count[1]=3. Release hold → req1 is granted the next cycle.
- Saturation (STATS_EN): force req0 to stall for 70000 cycles → stall_count[0] stays at 16'hFFFF.

Source files
------------

// File: rtl/cgra_regfile_arb_pkg.sv
// cgra_regfile_arb_pkg: shared constants and pointer sizing for the regfile write arbiter
package cgra_regfile_arb_pkg;
  localparam int NREQ_DEFAULT     = 4;
  localparam int LOG2REGS_DEFAULT = 3;
  localparam int SIZE_DEFAULT     = 32;
  localparam int STALL_CNT_W      = 16;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int PTR_W_DEFAULT = ptr_w(NREQ_DEFAULT);
  typedef logic [PTR_W_DEFAULT-1:0] rr_ptr_t;
endpackage

// File: rtl/cgra_rr_pick.sv
// cgra_rr_pick: first set bit of mask scanning upward from start with wrap-around
module cgra_rr_pick import cgra_regfile_arb_pkg::*; #(
  parameter int N = NREQ_DEFAULT,
  parameter int W = ptr_w(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  // descending scan so the entry closest to start is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[(int'(start) + k) % N]) begin
        found = 1'b1;
        idx   = W'((int'(start) + k) % N);
      end
    end
  end
endmodule

// File: rtl/cgra_regfile_write_arbiter.sv
// cgra_regfile_write_arbiter: two-port round-robin write arbiter for the PE register file (stats via CGRA_REGFILE_ARB_STATS_EN)
module cgra_regfile_write_arbiter import cgra_regfile_arb_pkg::*; #(
  parameter int NREQ     = NREQ_DEFAULT,
  parameter int log2regs = LOG2REGS_DEFAULT,
  parameter int size     = SIZE_DEFAULT
) (
  input  logic                     CGRA_Clock,
  input  logic                     CGRA_Reset,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*log2regs-1:0] req_addr,
  input  logic [NREQ*size-1:0]     req_data,
  output logic                     WE0,
  output logic                     WE1,
  output logic [log2regs-1:0]      address_in0,
  output logic [log2regs-1:0]      address_in1,
  output logic [size-1:0]          in0,
  output logic [size-1:0]          in1
`ifdef CGRA_REGFILE_ARB_STATS_EN
  ,
  output logic [NREQ*STALL_CNT_W-1:0] stall_count
`endif
);
  localparam int PW = ptr_w(NREQ);
  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t inc(input ptr_t p);
    return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

  ptr_t                rr_ptr, a_idx, b_idx, b_start;
  logic                a_found, b_found, grant_a, grant_b;
  logic [log2regs-1:0] a_addr;
  logic [NREQ-1:0]     b_mask;

  cgra_rr_pick #(.N(NREQ), .W(PW)) u_pick_a (
    .mask (req_valid),
    .start(rr_ptr),
    .found(a_found),
    .idx  (a_idx)
  );

  assign a_addr  = req_addr[a_idx*log2regs +: log2regs];
  assign b_start = inc(a_idx);

  // second candidate excludes A itself and anything targeting A's address
  always_comb begin
    b_mask = '0;
    for (int i = 0; i < NREQ; i++)
      b_mask[i] = req_valid[i] && (ptr_t'(i) != a_idx) && (req_addr[i*log2regs +: log2regs] != a_addr);
  end

  cgra_rr_pick #(.N(NREQ), .W(PW)) u_pick_b (
    .mask (b_mask),
    .start(b_start),
    .found(b_found),
    .idx  (b_idx)
  );

  assign grant_a   = a_found && !hold && !CGRA_Reset;
  assign grant_b   = grant_a && b_found;
  assign req_ready = (NREQ'(grant_a) << a_idx) | (NREQ'(grant_b) << b_idx);

  // register winners onto the regfile ports; idle ports keep address/data
  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      WE0         <= 1'b0;
      WE1         <= 1'b0;
      address_in0 <= '0;
      address_in1 <= '0;
      in0         <= '0;
      in1         <= '0;
      rr_ptr      <= '0;
    end else begin
      WE0 <= grant_a;
      WE1 <= grant_b;
      if (grant_a) begin
        address_in0 <= a_addr;
        in0         <= req_data[a_idx*size +: size];
      end
      if (grant_b) begin
        address_in1 <= req_addr[b_idx*log2regs +: log2regs];
        in1         <= req_data[b_idx*size +: size];
      end
      rr_ptr <= grant_b ? inc(b_idx) : grant_a ? inc(a_idx) : rr_ptr;
    end
  end

`ifdef CGRA_REGFILE_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] cnt [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_stall
    // saturating count of cycles requester i waits, hold cycles included
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
      if (CGRA_Reset) cnt[i] <= '0;
      else if (req_valid[i] && !req_ready[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
    end
    assign stall_count[i*STALL_CNT_W +: STALL_CNT_W] = cnt[i];
  end
`endif
endmodule

// File: tb/tb_cgra_regfile_write_arbiter.sv
// tb_cgra_regfile_write_arbiter: directed self-checking bench for the regfile write arbiter
module tb_cgra_regfile_write_arbiter;
  logic        CGRA_Clock = 1'b0;
  logic        CGRA_Reset;
  logic        hold;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_addr;
  logic [127:0] req_data;
  logic        WE0, WE1;
  logic [2:0]  address_in0, address_in1;
  logic [31:0] in0, in1;
`ifdef CGRA_REGFILE_ARB_STATS_EN
  logic [63:0] stall_count;
`endif
  logic [31:0] rf [8];
  int total = 0;
  int bad = 0;

  cgra_regfile_write_arbiter #(.NREQ(4), .log2regs(3), .size(32)) dut (
    .CGRA_Clock (CGRA_Clock),
    .CGRA_Reset (CGRA_Reset),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .WE0        (WE0),
    .WE1        (WE1),
    .address_in0(address_in0),
    .address_in1(address_in1),
    .in0        (in0),
    .in1        (in1)
`ifdef CGRA_REGFILE_ARB_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 CGRA_Clock = ~CGRA_Clock;

  always @(posedge CGRA_Clock) begin
    if (WE0) rf[address_in0] <= in0;
    if (WE1) rf[address_in1] <= in1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CGRA_Clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [31:0] d);
    req_addr[i*3 +: 3]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic pulse_reset;
    CGRA_Reset = 1'b1;
    #1;
    CGRA_Reset = 1'b0;
    #1;
  endtask

  initial begin
    CGRA_Reset = 1'b1;
    hold = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 32'hA0 + 32'(i));
    req_valid = 4'hF;
    #3;
    chk("rst_ready", req_ready, 4'b0000);
    tick;
    chk("rst_we0", WE0, 0);
    chk("rst_we1", WE1, 0);
    chk("rst_in0", in0, 0);
    CGRA_Reset = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 4'b0011);
    tick;
    chk("full1_we0", WE0, 1);
    chk("full1_a0", address_in0, 0);
    chk("full1_in0", in0, 32'hA0);
    chk("full1_we1", WE1, 1);
    chk("full1_a1", address_in1, 1);
    chk("full1_in1", in1, 32'hA1);
    chk("full1_ready", req_ready, 4'b1100);
    tick;
    chk("full2_a0", address_in0, 2);
    chk("full2_in0", in0, 32'hA2);
    chk("full2_a1", address_in1, 3);
    chk("full2_in1", in1, 32'hA3);
    chk("full2_ready", req_ready, 4'b0011);
    tick;
    chk("full3_a0", address_in0, 0);
    chk("full3_a1", address_in1, 1);
    chk("full3_ready", req_ready, 4'b1100);
    #2;
    CGRA_Reset = 1'b1;
    #1;
    chk("mid_rst_we0", WE0, 0);
    chk("mid_rst_we1", WE1, 0);
    chk("mid_rst_a1", address_in1, 0);
    chk("mid_rst_in1", in1, 0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    for (int i = 0; i < 4; i++) chk($sformatf("rf_full%0d", i), rf[i], 32'hA0 + 32'(i));
    #1;
    CGRA_Reset = 1'b0;
    req_valid = '0;
    tick;
    set_req(0, 3'd5, 32'd11);
    set_req(1, 3'd5, 32'd22);
    set_req(2, 3'd6, 32'd33);
    req_valid = 4'b0111;
    #1;
    chk("conf1_ready", req_ready, 4'b0101);
    tick;
    chk("conf1_we0", WE0, 1);
    chk("conf1_a0", address_in0, 5);
    chk("conf1_in0", in0, 32'd11);
    chk("conf1_we1", WE1, 1);
    chk("conf1_a1", address_in1, 6);
    chk("conf1_in1", in1, 32'd33);
    req_valid = 4'b0010;
    #1;
    chk("conf2_ready", req_ready, 4'b0010);
    tick;
    chk("conf2_we0", WE0, 1);
    chk("conf2_a0", address_in0, 5);
    chk("conf2_in0", in0, 32'd22);
    chk("conf2_we1", WE1, 0);
    chk("conf2_a1_hold", address_in1, 6);
    chk("conf2_in1_hold", in1, 32'd33);
    req_valid = '0;
    tick;
    tick;
    chk("rf5", rf[5], 32'd22);
    chk("rf6", rf[6], 32'd33);
    set_req(3, 3'd7, 32'hDEADBEEF);
    req_valid = 4'b1000;
    #1;
    chk("single_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    chk("single_we0", WE0, 1);
    chk("single_a0", address_in0, 7);
    chk("single_in0", in0, 32'hDEADBEEF);
    chk("single_we1", WE1, 0);
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 32'hA0 + 32'(i));
    req_valid = 4'hF;
    #1;
    chk("single_ptr_wrap", req_ready, 4'b0011);
    req_valid = '0;
    pulse_reset;
    hold = 1'b1;
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_ready", c), req_ready, 4'b0000);
      tick;
      chk($sformatf("hold%0d_we0", c), WE0, 0);
      chk($sformatf("hold%0d_we1", c), WE1, 0);
    end
`ifdef CGRA_REGFILE_ARB_STATS_EN
    chk("hold_stall1", stall_count[16 +: 16], 16'd3);
`endif
    hold = 1'b0;
    #1;
    chk("unhold_ready", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    chk("unhold_we0", WE0, 1);
    chk("unhold_a0", address_in0, 1);
    chk("unhold_in0", in0, 32'hA1);
    for (int i = 0; i < 4; i++) set_req(i, 3'd4, 32'hB0 + 32'(i));
    req_valid = 4'hF;
    #1;
    chk("same_addr_ready", req_ready, 4'b0100);
    tick;
    chk("same_addr_we0", WE0, 1);
    chk("same_addr_a0", address_in0, 4);
    chk("same_addr_in0", in0, 32'hB2);
    chk("same_addr_we1", WE1, 0);
    chk("same_addr_next_ready", req_ready, 4'b1000);
    req_valid = '0;
    tick;
`ifdef CGRA_REGFILE_ARB_STATS_EN
    pulse_reset;
    hold = 1'b1;
    req_valid = 4'b0001;
    repeat (70000) tick;
    chk("sat_stall0", stall_count[15:0], 16'hFFFF);
    chk("sat_stall1", stall_count[31:16], 16'd0);
    hold = 1'b0;
    req_valid = '0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
